// File: rtl/core_mem_bridge.sv
// Arbitrates the core's fetch and data pulse requests onto one req/gnt/rvalid memory port, with dmem taking priority over imem.
// Defining CORE_MEM_BRIDGE_PROTO_ERR_EN adds a sticky proto_err_o output.
module core_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  input  logic                    imem_read_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  output logic                    imem_ready_o,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
  input  logic                    dmem_read_i,
  input  logic                    dmem_write_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_ready_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef CORE_MEM_BRIDGE_PROTO_ERR_EN
  ,
  output logic                    proto_err_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state;
  logic                    imem_pend;
  logic                    dmem_pend;
  logic                    sel_dmem;
  logic                    dmem_we;
  logic [ADDR_WIDTH-1:0]   imem_addr;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb;
  logic                    dmem_pulse;
  logic                    imem_take;
  logic                    dmem_take;

  // A pulse on a side that is already pending is dropped without touching its captured fields.
  assign dmem_pulse = dmem_read_i | dmem_write_i;
  assign imem_take  = imem_read_i & ~imem_pend;
  assign dmem_take  = dmem_pulse & ~dmem_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      dmem_we    <= 1'b0;
    end else begin
      if (imem_take) begin
        imem_addr <= imem_addr_i;
      end
      if (dmem_take) begin
        dmem_addr  <= dmem_addr_i;
        dmem_wdata <= dmem_wdata_i;
        dmem_wstrb <= dmem_wstrb_i;
        dmem_we    <= dmem_write_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      imem_pend    <= 1'b0;
      dmem_pend    <= 1'b0;
      sel_dmem     <= 1'b0;
      imem_rdata_o <= '0;
      imem_ready_o <= 1'b0;
      dmem_rdata_o <= '0;
      dmem_ready_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_wstrb_o  <= '0;
    end else begin
      imem_ready_o <= 1'b0;
      dmem_ready_o <= 1'b0;
      if (imem_take) begin
        imem_pend <= 1'b1;
      end
      if (dmem_take) begin
        dmem_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (dmem_pend) begin
            sel_dmem    <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dmem_we;
            mem_addr_o  <= dmem_addr;
            mem_wdata_o <= dmem_wdata;
            mem_wstrb_o <= dmem_we ? dmem_wstrb : '1;
            state       <= REQ;
          end else if (imem_pend) begin
            sel_dmem    <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= imem_addr;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // The served side's pending flag cannot be re-set on this edge, since its pulses are dropped while pending.
          if (mem_rvalid_i) begin
            if (sel_dmem) begin
              dmem_ready_o <= 1'b1;
              dmem_pend    <= 1'b0;
              if (!dmem_we) begin
                dmem_rdata_o <= mem_rdata_i;
              end
            end else begin
              imem_ready_o <= 1'b1;
              imem_pend    <= 1'b0;
              imem_rdata_o <= mem_rdata_i;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORE_MEM_BRIDGE_PROTO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_o <= 1'b0;
    end else if ((imem_read_i & imem_pend) | (dmem_pulse & dmem_pend) |
                 (dmem_read_i & dmem_write_i) | (mem_rvalid_i & (state != WAIT))) begin
      proto_err_o <= 1'b1;
    end
  end
`endif

endmodule
